dice_player: RTL and testbench

DICE_PLAYER -- requirements
Module: dice_player

---
 rtl/dice_player.sv | 153 +++++++++++++++
 tb/tb_dice_player.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_player.sv
// Automated player for a two-die game: issues timed roll pulses, decodes the dice
// displays and keeps the game result. Optional tallies are built with DICE_PLAYER_STATS_EN.
module dice_player #(
    parameter int ROLL_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_ROLLS     = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [6:0] i_disp1,
    input  logic [6:0] i_disp2,
    input  logic       i_win,
    input  logic       i_lose,
    output logic       o_roll,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_die1,
    output logic [2:0] o_die2,
    output logic [3:0] o_sum,
    output logic [1:0] o_result,
    output logic       o_seg_err,
    output logic [3:0] o_rolls,
    output logic [7:0] o_win_count,
    output logic [7:0] o_lose_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ROLL   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_WIN   = 2'b01;
    localparam logic [1:0] RES_LOSE  = 2'b10;
    localparam logic [1:0] RES_ABORT = 2'b11;

    function automatic logic [2:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b0000110: f_decode = 3'd1;
            7'b1011011: f_decode = 3'd2;
            7'b1001111: f_decode = 3'd3;
            7'b1100110: f_decode = 3'd4;
            7'b1101101: f_decode = 3'd5;
            7'b1111101: f_decode = 3'd6;
            default:    f_decode = 3'd0;
        endcase
    endfunction

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_die1, r_die2;
    logic [3:0] r_sum;
    logic [1:0] r_result;
    logic       r_seg_err;
    logic [3:0] r_rolls;

    logic [2:0] w_d1, w_d2;
    assign w_d1 = f_decode(i_disp1);
    assign w_d2 = f_decode(i_disp2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_die1    <= 3'd0;
            r_die2    <= 3'd0;
            r_sum     <= 4'd0;
            r_result  <= RES_NONE;
            r_seg_err <= 1'b0;
            r_rolls   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_rolls   <= 4'd0;
                    r_result  <= RES_NONE;
                    r_seg_err <= 1'b0;
                    r_cnt     <= 8'd0;
                    r_state   <= S_ROLL;
                end
                S_ROLL: if (r_cnt == 8'(ROLL_CYCLES - 1)) begin
                    r_cnt   <= 8'd0;
                    r_rolls <= r_rolls + 4'd1;
                    r_state <= S_SETTLE;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                S_SETTLE: if (r_cnt == 8'(SETTLE_CYCLES - 1)) begin
                    r_cnt   <= 8'd0;
                    r_state <= S_SAMPLE;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                S_SAMPLE: begin
                    r_die1 <= w_d1;
                    r_die2 <= w_d2;
                    r_sum  <= {1'b0, w_d1} + {1'b0, w_d2};
                    if (w_d1 == 3'd0 || w_d2 == 3'd0) r_seg_err <= 1'b1;
                    // win has priority over lose when both are reported
                    if (i_win) begin
                        r_result <= RES_WIN;
                        r_state  <= S_DONE;
                    end else if (i_lose) begin
                        r_result <= RES_LOSE;
                        r_state  <= S_DONE;
                    end else if (r_rolls < 4'(MAX_ROLLS)) begin
                        r_state <= S_ROLL;
                    end else begin
                        r_result <= RES_ABORT;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DICE_PLAYER_STATS_EN
    logic [7:0] r_win_count, r_lose_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win_count  <= 8'd0;
            r_lose_count <= 8'd0;
        end else if (r_state == S_DONE) begin
            if (r_result == RES_WIN && r_win_count != 8'hFF)
                r_win_count <= r_win_count + 8'd1;
            if (r_result == RES_LOSE && r_lose_count != 8'hFF)
                r_lose_count <= r_lose_count + 8'd1;
        end
    end

    assign o_win_count  = r_win_count;
    assign o_lose_count = r_lose_count;
`else
    assign o_win_count  = 8'd0;
    assign o_lose_count = 8'd0;
`endif

    // Status outputs decode straight from the state flop so reset drops them at once.
    assign o_roll    = (r_state == S_ROLL);
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_die1    = r_die1;
    assign o_die2    = r_die2;
    assign o_sum     = r_sum;
    assign o_result  = r_result;
    assign o_seg_err = r_seg_err;
    assign o_rolls   = r_rolls;

endmodule

// File: tb/tb_dice_player.sv
// Directed bench for dice_player: timing, decode, results, tallies and mid-game reset.
module tb_dice_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] disp1, disp2;
    logic       win, lose;
    logic       roll, busy, done, seg_err;
    logic [2:0] die1, die2;
    logic [3:0] sum, rolls;
    logic [1:0] result;
    logic [7:0] win_count, lose_count;

    int passed = 0;
    int total  = 0;

    // Roll pulse monitor (cumulative; games use differences from a snapshot)
    int pulses   = 0;
    int bad_len  = 0;
    int cur_len  = 0;
    int done_cnt = 0;

    // Flag stimulus: a flag goes high once the game has issued flag_after roll pulses
    int   base = 0;
    int   flag_after = 1;
    logic win_en = 1'b0;
    logic lose_en = 1'b0;

    assign win  = win_en  && ((pulses - base) >= flag_after);
    assign lose = lose_en && ((pulses - base) >= flag_after);

`ifdef DICE_PLAYER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    dice_player dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_disp1      (disp1),
        .i_disp2      (disp2),
        .i_win        (win),
        .i_lose       (lose),
        .o_roll       (roll),
        .o_busy       (busy),
        .o_done       (done),
        .o_die1       (die1),
        .o_die2       (die2),
        .o_sum        (sum),
        .o_result     (result),
        .o_seg_err    (seg_err),
        .o_rolls      (rolls),
        .o_win_count  (win_count),
        .o_lose_count (lose_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (roll) cur_len++;
        else if (cur_len != 0) begin
            pulses++;
            if (cur_len != 10) bad_len++;
            cur_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One start pulse, then wait (bounded) for done; lat counts edges from the start edge.
    task automatic play(output int lat);
        base = pulses;
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) break;
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            lat = -1;
        end
        @(negedge clk);  // back in IDLE with tallies updated
    endtask

    int lat;
    int dbase;

    initial begin
        rst_n = 1'b0; start = 1'b0;
        disp1 = 7'b0; disp2 = 7'b0;
        repeat (2) @(negedge clk);
        check("rst_roll", roll, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_die1", die1, 0);
        check("rst_sum", sum, 0);
        check("rst_result", result, 0);
        check("rst_rolls", rolls, 0);
        check("rst_wcnt", win_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single winning roll: 2 + 6
        disp1 = 7'b1011011; disp2 = 7'b1111101;
        win_en = 1'b1; lose_en = 1'b0; flag_after = 1;
        play(lat);
        check("A_latency", lat, 16);
        check("A_pulses", pulses - base, 1);
        check("A_pulse_len", bad_len, 0);
        check("A_die1", die1, 2);
        check("A_die2", die2, 6);
        check("A_sum", sum, 8);
        check("A_result", result, 2'b01);
        check("A_rolls", rolls, 1);
        check("A_seg_err", seg_err, 0);
        check("A_busy", busy, 0);
        check("A_wcnt", win_count, STATS ? 1 : 0);

        // Two neutral samples then lose: 3 + 4
        disp1 = 7'b1001111; disp2 = 7'b1100110;
        win_en = 1'b0; lose_en = 1'b1; flag_after = 3;
        play(lat);
        check("B_pulses", pulses - base, 3);
        check("B_pulse_len", bad_len, 0);
        check("B_rolls", rolls, 3);
        check("B_sum", sum, 7);
        check("B_result", result, 2'b10);
        check("B_lcnt", lose_count, STATS ? 1 : 0);
        check("B_wcnt", win_count, STATS ? 1 : 0);

        // Never a flag: abort after MAX_ROLLS
        win_en = 1'b0; lose_en = 1'b0;
        play(lat);
        check("C_pulses", pulses - base, 15);
        check("C_pulse_len", bad_len, 0);
        check("C_rolls", rolls, 15);
        check("C_result", result, 2'b11);
        check("C_wcnt", win_count, STATS ? 1 : 0);
        check("C_lcnt", lose_count, STATS ? 1 : 0);

        // Illegal die-1 pattern with a win
        disp1 = 7'b0111111; disp2 = 7'b0000110;
        win_en = 1'b1; flag_after = 1;
        play(lat);
        check("D_die1", die1, 0);
        check("D_die2", die2, 1);
        check("D_sum", sum, 1);
        check("D_seg_err", seg_err, 1);
        check("D_result", result, 2'b01);

        // Both flags: win takes priority, seg_err cleared by the new start
        disp1 = 7'b1101101; disp2 = 7'b1101101;
        win_en = 1'b1; lose_en = 1'b1; flag_after = 1;
        play(lat);
        check("E_seg_err", seg_err, 0);
        check("E_sum", sum, 10);
        check("E_result", result, 2'b01);
        check("E_wcnt", win_count, STATS ? 3 : 0);
        repeat (5) @(negedge clk);
        check("E_hold_sum", sum, 10);

        // Reset on the 5th ROLL cycle
        lose_en = 1'b0;
        dbase = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("F_roll_before", roll, 1);
        rst_n = 1'b0;
        #1;
        check("F_roll", roll, 0);
        check("F_busy", busy, 0);
        check("F_rolls", rolls, 0);
        check("F_wcnt", win_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("F_no_done", done_cnt - dbase, 0);
        check("F_lcnt", lose_count, 0);

        // 256 winning games: tally saturates
        win_en = 1'b1; flag_after = 1;
        disp1 = 7'b0000110; disp2 = 7'b0000110;
        for (int g = 0; g < 256; g++) play(lat);
        check("G_wcnt_sat", win_count, STATS ? 255 : 0);
        check("G_lcnt", lose_count, 0);
        check("G_sum", sum, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
